// File: rtl/dispatch_buffer.sv
// Decoupling FIFO between decode and issue_queue: up to two entries in and
// two out per cycle, with a decode-side ready derived only from stored occupancy.
module dispatch_buffer #(
  parameter int DEPTH     = 4,
  parameter int ELEM_W    = 32,
  parameter int IQ_ADDR_W = 4,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [1:0][ELEM_W-1:0] dec_data,
  input  logic [1:0]             dec_data_number,
  output logic                   dec_ready,
  input  logic [IQ_ADDR_W-1:0]   iq_size_left,
  output logic [1:0][ELEM_W-1:0] iq_data,
  output logic [1:0]             iq_data_number,
  output logic [CNT_W-1:0]       occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ELEM_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  free_s;
  logic [1:0]        n_push_s, n_pop_s, cnt_cap_s, room_cap_s;
  logic [PTR_W-1:0]  head_p1_s, tail_p1_s;

  function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction

  assign free_s    = CNT_W'(DEPTH) - count_q;
  assign dec_ready = rst && (free_s >= CNT_W'(2));
  assign occupancy = rst ? count_q : '0;
  assign head_p1_s = head_q + PTR_W'(1);
  assign tail_p1_s = tail_q + PTR_W'(1);

  // Pop/push sizing, output lanes and next-state pointers
  always_comb begin
    cnt_cap_s  = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];
    room_cap_s = (iq_size_left > IQ_ADDR_W'(1)) ? 2'd2 : iq_size_left[1:0];
    n_pop_s    = 2'd0;
    n_push_s   = 2'd0;
    if (rst && !flush) begin
      n_pop_s = min2(cnt_cap_s, room_cap_s);
    end else begin
      n_pop_s = 2'd0;
    end
    // An illegal lane count of 3 is treated as a full pair
    if (dec_ready && !flush) begin
      n_push_s = (dec_data_number == 2'd3) ? 2'd2 : dec_data_number;
    end else begin
      n_push_s = 2'd0;
    end

    iq_data        = '0;
    iq_data_number = n_pop_s;
    if (n_pop_s != 2'd0) begin
      iq_data[0] = mem_q[head_q];
    end else begin
      iq_data[0] = '0;
    end
    if (n_pop_s == 2'd2) begin
      iq_data[1] = mem_q[head_p1_s];
    end else begin
      iq_data[1] = '0;
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(n_pop_s);
      tail_d  = tail_q + PTR_W'(n_push_s);
      count_d = count_q + CNT_W'(n_push_s) - CNT_W'(n_pop_s);
    end
  end

  // Pointer, occupancy and storage registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (n_push_s != 2'd0) begin
        mem_q[tail_q] <= dec_data[0];
      end
      if (n_push_s == 2'd2) begin
        mem_q[tail_p1_s] <= dec_data[1];
      end
    end
  end

endmodule
